mc_maindec: RTL
===============

# mc_maindec

Multicycle main controller for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and multiplexer selects. It also produces the 2-bit `aluop` consumed by the ALU decoder. It sits beside the ALU decoder in the controller and takes `op` from the instruction register and a ready handshake from the unified instruction/data memory.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `op`  in  6  opcode field of the instruction register; stable from DECODE until return to FETCH
- `memready`  in  1  memory completes the current access this cycle
- `pcwrite`, `irwrite`, `regwrite`, `memwrite`, `branch`  out  1 each  write enables / branch qualify
- `iord`, `alusrca`, `regdst`, `memtoreg`  out  1 each  mux selects
- `alusrcb`  out  2  ALU B select (00 reg, 01 const 4, 10 signimm, 11 signimm<<2)
- `pcsrc`  out  2  PC select (00 ALU result, 01 ALUOut, 10 jump target)
- `aluop`  out  2  to ALU decoder (00 add, 01 sub, 10 use funct)
- `state`  out  4  current state encoding, for debug and verification

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010. Every other opcode is illegal.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Encodings 12–15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH→DECODE when `memready`=1, else stay in FETCH.
  - DECODE→MEMADR (lw, sw), RTYPEEX, BEQEX, ADDIEX, JEX. An illegal `op` goes to FETCH.
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB when `memready`, else stay.
  - MEMWR→FETCH when `memready`, else stay.
  - RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX→FETCH.
- Outputs are Moore decodes of `state`. The only exception is FETCH `pcwrite` and `irwrite`, which equal `memready`. Any output not listed for a state is 0.
  - FETCH: `alusrcb`=01, `irwrite`=`pcwrite`=`memready`.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1, held until `memready`.
  - RTYPEEX: `alusrca`=1, `aluop`=10.
  - RTYPEWB: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- An illegal opcode produces no writes; it costs the 2 cycles FETCH and DECODE.

## Timing
- Reset (`reset`=0):
  - `state` goes to FETCH immediately, without waiting for a clock edge.
  - While reset is held, `pcwrite`, `irwrite`, `regwrite`, `memwrite` and `branch` are forced to 0.
  - Other outputs show the FETCH decode: `alusrcb`=01, everything else 0.
- Reset deasserted mid-instruction: execution restarts at FETCH, and no partially issued write occurs after release.
- Latency with `memready` tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each cycle with `memready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay constant during the stall, except that FETCH `pcwrite`/`irwrite` stay 0.
- `op` is sampled only in DECODE and MEMADR. Changes of `op` in any other state have no effect.

## Test plan
- Reset: pulse `reset`=0 asynchronously mid-RTYPEEX → `state`=0 before the next edge, all enables 0 during reset. First cycle after release with `memready`=1 gives `pcwrite`=`irwrite`=1.
- lw, `op`=100011, `memready`=1 → states 0,1,2,3,4,0. `regwrite`=1 and `memtoreg`=1 only in state 4. `aluop`=00 throughout.
- sw with `memready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 consecutive cycles, then `state`=0. `regwrite` never 1.
- R-type `op`=000000 → `aluop`=10 in state 6. State 7 has `regdst`=1 and `regwrite`=1. beq `op`=000100 → state 8 with `aluop`=01, `branch`=1, `pcsrc`=01.
- j `op`=000010 → state 11 with `pcwrite`=1 and `pcsrc`=10. Illegal `op`=111111 → DECODE then FETCH, with no write enable ever 1 apart from the FETCH `pcwrite`/`irwrite`.
- FETCH stall: `memready`=0 for 2 cycles → `state` holds at 0 and `pcwrite`=`irwrite`=0. When `memready`=1 both are 1 for one cycle, then `state`=1.

Source files
------------

// File: rtl/mc_maindec_if.sv
// Controller-to-datapath bundle for the multicycle main decoder: the opcode
// and memory ready come in, and the enables, selects, aluop and debug state
// go out.
interface mc_maindec_if;
  logic [5:0] op;
  logic       memready;
  logic       pcwrite;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       branch;
  logic       iord;
  logic       alusrca;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic [3:0] state;

  // Controller side: reads the opcode and ready, and drives every control.
  modport master (
    input  op, memready,
    output pcwrite, irwrite, regwrite, memwrite, branch,
           iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop, state
  );

  // Datapath side: supplies the opcode and ready, and consumes the controls.
  modport slave (
    output op, memready,
    input  pcwrite, irwrite, regwrite, memwrite, branch,
           iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop, state
  );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller. A Moore FSM walks each instruction
// through fetch, decode, execute, memory and writeback. It stalls in the
// memory-access states until the unified memory signals ready.
module mc_maindec (
  input  logic         clk,
  input  logic         reset,   // asynchronous, active low
  mc_maindec_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register; reset drops straight back to FETCH without a clock.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; the opcode is only looked at in DECODE and MEMADR.
  // NOTE: default assignment first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (bus.memready) state_d = DECODE;
      DECODE: begin
        unique case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;   // illegal opcode: no writes at all
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (bus.memready) state_d = MEMWB;
      MEMWR:   if (bus.memready) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX: state_d = FETCH;
      default: state_d = FETCH;            // encodings 12-15 recover here
    endcase
  end

  // Moore output decode. FETCH's PC and IR write enables follow memready.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = bus.memready;
        ctrl.pcwrite = bus.memready;
      end
      DECODE:  ctrl.alusrcb = 2'b11;
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD:   ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 2'b10;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = 2'b01;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      ADDIWB:  ctrl.regwrite = 1'b1;
      JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Write enables are masked while reset is held. Otherwise the FETCH decode
  // would pass memready through to pcwrite/irwrite during reset.
  assign bus.pcwrite  = ctrl.pcwrite  & reset;
  assign bus.irwrite  = ctrl.irwrite  & reset;
  assign bus.regwrite = ctrl.regwrite & reset;
  assign bus.memwrite = ctrl.memwrite & reset;
  assign bus.branch   = ctrl.branch   & reset;
  assign bus.iord     = ctrl.iord;
  assign bus.alusrca  = ctrl.alusrca;
  assign bus.regdst   = ctrl.regdst;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.alusrcb  = ctrl.alusrcb;
  assign bus.pcsrc    = ctrl.pcsrc;
  assign bus.aluop    = ctrl.aluop;
  assign bus.state    = state_q;

endmodule
